vlat_dp_scheduler: RTL and testbench

- Round-robin scheduler that shares one variable-latency datapath unit among NUM_REQ requesters.
- The unit accepts a one-cycle data_valid-style pulse and returns a result 1..MAX_LAT cycles later.
- The scheduler keeps one transaction outstanding, routes each result back to its originating requester, and flags late and spurious responses.
- It sits between the requester agents and the shared unit, in the same clock domain.

---
 rtl/vlat_dp_scheduler.sv | 165 ++++++++++++++++
 tb/tb_vlat_dp_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vlat_dp_scheduler.sv
// Round-robin arbiter sharing one variable-latency unit; one transaction in flight, results routed back to owner.
// Issue one cycle after grant, response one cycle after result strobe; requesters hold req_valid until req_ready.
module vlat_dp_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 10,
  parameter int MAX_LAT = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        dp_valid,
  output logic [DATA_W-1:0]           dp_data,
  input  logic                        dp_out_valid,
  input  logic [DATA_W-1:0]           dp_out_data,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy,
  output logic                        timeout_err,
  output logic                        spurious_err,
  output logic [7:0]                  err_cnt
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]     cur_id, cur_id_nxt;
  logic [CNT_W-1:0]    lat_cnt, lat_cnt_nxt;

  logic                gnt_found;
  logic [ID_W-1:0]     gnt_id;
  logic [DATA_W-1:0]   gnt_dat;
  logic [ID_W:0]       cand_sum;

  logic [NUM_REQ-1:0]  req_ready_nxt;
  logic                dp_valid_nxt;
  logic [DATA_W-1:0]   dp_data_nxt;
  logic [NUM_REQ-1:0]  rsp_valid_nxt;
  logic [DATA_W-1:0]   rsp_data_nxt;
  logic                timeout_nxt;
  logic                spurious_nxt;
  logic [7:0]          err_cnt_nxt;

  // First requesting index at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand_sum  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!gnt_found && req_valid[cand_sum[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = cand_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        gnt_dat = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    cur_id_nxt    = cur_id;
    lat_cnt_nxt   = lat_cnt;
    req_ready_nxt = '0;
    dp_valid_nxt  = 1'b0;
    dp_data_nxt   = dp_data;
    rsp_valid_nxt = '0;
    rsp_data_nxt  = rsp_data;
    timeout_nxt   = 1'b0;
    spurious_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        spurious_nxt = dp_out_valid;
        if (gnt_found) begin
          cur_id_nxt    = gnt_id;
          dp_data_nxt   = gnt_dat;
          dp_valid_nxt  = 1'b1;
          req_ready_nxt = NUM_REQ'(1) << gnt_id;
          state_nxt     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        spurious_nxt = dp_out_valid;
        rr_ptr_nxt   = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + ID_W'(1);
        lat_cnt_nxt  = CNT_W'(1);
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (dp_out_valid) begin
          rsp_valid_nxt = NUM_REQ'(1) << cur_id;
          rsp_data_nxt  = dp_out_data;
          state_nxt     = ST_IDLE;
        end else if (lat_cnt == CNT_W'(MAX_LAT)) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          lat_cnt_nxt = lat_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Timeout and spurious are mutually exclusive by state, so at most +1 per cycle.
    err_cnt_nxt = err_cnt;
    if ((timeout_nxt || spurious_nxt) && (err_cnt != 8'hFF)) begin
      err_cnt_nxt = err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      cur_id       <= '0;
      lat_cnt      <= '0;
      req_ready    <= '0;
      dp_valid     <= 1'b0;
      dp_data      <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      spurious_err <= 1'b0;
      err_cnt      <= '0;
    end else begin
      rr_ptr       <= rr_ptr_nxt;
      cur_id       <= cur_id_nxt;
      lat_cnt      <= lat_cnt_nxt;
      req_ready    <= req_ready_nxt;
      dp_valid     <= dp_valid_nxt;
      dp_data      <= dp_data_nxt;
      rsp_valid    <= rsp_valid_nxt;
      rsp_data     <= rsp_data_nxt;
      busy         <= (state_nxt != ST_IDLE);
      timeout_err  <= timeout_nxt;
      spurious_err <= spurious_nxt;
      err_cnt      <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_vlat_dp_scheduler.sv
// Directed bench for vlat_dp_scheduler: grant order, latency window, error counting and async reset.
module tb_vlat_dp_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 10;
  localparam int MAX_LAT = 3;

  logic                       clk;
  logic                       reset_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       dp_valid;
  logic [DATA_W-1:0]          dp_data;
  logic                       dp_out_valid;
  logic [DATA_W-1:0]          dp_out_data;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [DATA_W-1:0]          rsp_data;
  logic                       busy;
  logic                       timeout_err;
  logic                       spurious_err;
  logic [7:0]                 err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  vlat_dp_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_LAT(MAX_LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .dp_valid     (dp_valid),
    .dp_data      (dp_data),
    .dp_out_valid (dp_out_valid),
    .dp_out_data  (dp_out_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .spurious_err (spurious_err),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [DATA_W-1:0] v);
    req_data[idx*DATA_W +: DATA_W] = v;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    req_valid    = '0;
    dp_out_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  // Ticks until dp_valid is seen, bounded.
  task automatic wait_dp(output bit found);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (dp_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("dp_valid_seen", 32'(found), 32'd1);
  endtask

  // One full transaction: issue, unit answers lat cycles after dp_valid, response check.
  task automatic run_txn(input string tag, input logic [NUM_REQ-1:0] exp_gnt,
                         input logic [DATA_W-1:0] exp_dat, input int lat,
                         input logic [DATA_W-1:0] rdat, input bit drop);
    bit found;
    wait_dp(found);
    if (!found) return;
    check({tag, "_req_ready"}, 32'(req_ready), 32'(exp_gnt));
    check({tag, "_dp_data"},   32'(dp_data),   32'(exp_dat));
    check({tag, "_busy"},      32'(busy),      32'd1);
    if (drop) req_valid = req_valid & ~exp_gnt;
    repeat (lat) tick();
    dp_out_valid = 1'b1;
    dp_out_data  = rdat;
    tick();
    dp_out_valid = 1'b0;
    check({tag, "_rsp_valid"}, 32'(rsp_valid),   32'(exp_gnt));
    check({tag, "_rsp_data"},  32'(rsp_data),    32'(rdat));
    check({tag, "_no_tmo"},    32'(timeout_err), 32'd0);
  endtask

  initial begin
    bit found;
    bit saw_rsp;
    bit saw_sp;

    reset_n      = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    dp_out_valid = 1'b0;
    dp_out_data  = '0;
    #2;
    check("rst_dp_valid",  32'(dp_valid),  32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    do_reset();

    // Single requester, latency 2.
    req_valid = 4'b0010;
    set_data(1, 10'd37);
    run_txn("single", 4'b0010, 10'd37, 2, 10'd37, 1'b1);
    check("single_err_cnt", 32'(err_cnt), 32'd0);
    check("single_idle",    32'(busy),    32'd0);

    // All requesters held; latency 1; rotation 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 10'(10 * (i + 1)));
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_txn("rr", 4'(1 << (i % 4)), 10'(10 * ((i % 4) + 1)), 1, 10'(100 + i), 1'b0);
    end
    req_valid = '0;

    // Latency exactly MAX_LAT is accepted.
    req_valid = 4'b0001;
    set_data(0, 10'd55);
    run_txn("lat3", 4'b0001, 10'd55, 3, 10'd66, 1'b1);
    check("lat3_err_cnt", 32'(err_cnt), 32'd0);

    // Latency MAX_LAT+1 times out, then the late strobe is spurious.
    req_valid = 4'b0001;
    set_data(0, 10'd77);
    wait_dp(found);
    req_valid = '0;
    repeat (3) tick();
    check("tmo_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("tmo_pulse",     32'(timeout_err), 32'd1);
    check("tmo_no_rsp",    32'(rsp_valid),   32'd0);
    check("tmo_err_cnt",   32'(err_cnt),     32'd1);
    check("tmo_busy",      32'(busy),        32'd0);
    dp_out_valid = 1'b1;
    dp_out_data  = 10'd78;
    tick();
    dp_out_valid = 1'b0;
    check("late_spurious", 32'(spurious_err), 32'd1);
    check("late_tmo_clr",  32'(timeout_err),  32'd0);
    check("late_no_rsp",   32'(rsp_valid),    32'd0);
    check("late_err_cnt",  32'(err_cnt),      32'd2);
    tick();
    check("sp_one_cycle",  32'(spurious_err), 32'd0);

    // Pointer moved to 3 by serving requester 2; then 3 wins before 2, and 3 waits for 2.
    req_valid = 4'b0100;
    set_data(2, 10'd5);
    run_txn("p2", 4'b0100, 10'd5, 1, 10'd6, 1'b1);
    set_data(2, 10'd21);
    set_data(3, 10'd31);
    req_valid = 4'b1100;
    run_txn("p3first",  4'b1000, 10'd31, 1, 10'd32, 1'b0);
    run_txn("p2second", 4'b0100, 10'd21, 1, 10'd22, 1'b1);
    run_txn("p3again",  4'b1000, 10'd31, 2, 10'd33, 1'b1);

    // 300 idle strobes saturate the error counter.
    saw_rsp = 1'b0;
    saw_sp  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      dp_out_valid = 1'b1;
      tick();
      dp_out_valid = 1'b0;
      if (rsp_valid != '0) saw_rsp = 1'b1;
      if (spurious_err) saw_sp = 1'b1;
      tick();
    end
    check("sat_err_cnt",  32'(err_cnt), 32'd255);
    check("sat_no_rsp",   32'(saw_rsp), 32'd0);
    check("sat_spurious", 32'(saw_sp),  32'd1);

    // Reset in WAIT; pointer was left at 2 by this grant, reset returns it to 0.
    req_valid = 4'b0010;
    set_data(1, 10'd9);
    wait_dp(found);
    req_valid = '0;
    tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_busy",      32'(busy),      32'd0);
    check("mid_err_cnt",   32'(err_cnt),   32'd0);
    check("mid_dp_valid",  32'(dp_valid),  32'd0);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_dp_data",   32'(dp_data),   32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    set_data(0, 10'd3);
    set_data(2, 10'd4);
    req_valid    = 4'b0101;
    dp_out_valid = 1'b1;
    dp_out_data  = 10'd9;
    tick();
    dp_out_valid = 1'b0;
    req_valid    = 4'b0100;
    check("post_spurious",  32'(spurious_err), 32'd1);
    check("post_req_ready", 32'(req_ready),    32'd1);
    check("post_dp_data",   32'(dp_data),      32'd3);
    check("post_no_rsp",    32'(rsp_valid),    32'd0);
    check("post_err_cnt",   32'(err_cnt),      32'd1);
    req_valid = '0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
